// File: rtl/stack_cpu_param_if.sv
// Op handshake and status bundle between the stack calculator core and its driver.
// The master drives op_valid/op/in_data; the core (slave) returns status and results.
interface stack_cpu_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic             op_valid;
  logic             op_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in_data;
  logic             done;
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] top_word;
  logic [SPW-1:0]   depth;
  logic             carry;
  logic             err;

  modport master (
    output op_valid, op, in_data,
    input  op_ready, done, out_data, top_word, depth, carry, err
  );

  modport slave (
    input  op_valid, op, in_data,
    output op_ready, done, out_data, top_word, depth, carry, err
  );
endinterface

// File: rtl/stack_cpu_param.sv
// Parametrised stack calculator core: DEPTH-entry WIDTH-bit stack, single-issue op
// handshake, sticky error flag and a multi-cycle restoring divider.
module stack_cpu_param #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  stack_cpu_param_if.slave  bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(WIDTH + 1);
  localparam logic [SPW-1:0] FULL = SPW'(DEPTH);

  localparam logic [3:0] OP_PUSH = 4'h1, OP_POP  = 4'h2, OP_OUT  = 4'h3, OP_SWAP = 4'h4;
  localparam logic [3:0] OP_DUP  = 4'h5, OP_PUSF = 4'h6, OP_BINA = 4'h8, OP_MULT = 4'h9;
  localparam logic [3:0] OP_IDIV = 4'hA, OP_CLFL = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV, S_WR2} state_t;
  state_t r_state, w_state_nxt;

  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_arg;
  logic [SPW-1:0]   r_depth, w_depth_nxt;
  logic             r_carry, w_carry_nxt, r_err, w_err_nxt, r_done;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_stk [DEPTH];
  logic [WIDTH-1:0] r_hi, r_quo, r_rem, r_dvs;

  logic             w_we_a, w_we_b, w_ld_mul, w_ld_div, w_div_zero;
  logic [AW-1:0]    w_idx_a, w_idx_b, w_idx_t, w_idx_s, w_idx_p;
  logic [WIDTH-1:0] w_dat_a, w_dat_b, w_t, w_s, w_rem_nxt, w_quo_nxt;
  logic [WIDTH:0]   w_bina, w_partial;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_one_ok, w_two_ok, w_full, w_ge;

  // Binary op: returns {carry_out, result}; logic ops pass the incoming carry through.
  function automatic logic [WIDTH:0] f_bina(input logic [2:0] sub, input logic [WIDTH-1:0] s,
                                            input logic [WIDTH-1:0] t, input logic cin);
    logic [WIDTH:0] r;
    case (sub)
      3'd0:    r = {1'b0, s} + {1'b0, t};
      3'd1:    r = {1'b0, s} + {1'b0, t} + {{WIDTH{1'b0}}, cin};
      3'd2:    r = {1'b0, s} - {1'b0, t};
      3'd3:    r = {cin, s & t};
      3'd4:    r = {cin, s | t};
      3'd5:    r = {cin, s ^ t};
      default: r = {cin, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  assign w_idx_t  = AW'(r_depth - SPW'(1));
  assign w_idx_s  = AW'(r_depth - SPW'(2));
  assign w_idx_p  = AW'(r_depth);
  assign w_t      = r_stk[w_idx_t];
  assign w_s      = r_stk[w_idx_s];
  assign w_one_ok = (r_depth != '0);
  assign w_two_ok = (r_depth >= SPW'(2));
  assign w_full   = (r_depth == FULL);
  assign w_bina   = f_bina(3'(r_arg), w_s, w_t, r_carry);
  assign w_prod   = (2*WIDTH)'(w_s) * (2*WIDTH)'(w_t);

  // Restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
  assign w_partial = {r_rem, r_quo[WIDTH-1]};
  assign w_ge      = (w_partial >= {1'b0, r_dvs});
  assign w_rem_nxt = w_ge ? WIDTH'(w_partial - {1'b0, r_dvs}) : WIDTH'(w_partial);
  assign w_quo_nxt = {r_quo[WIDTH-2:0], w_ge};

  always_comb begin
    w_state_nxt = r_state;
    w_depth_nxt = r_depth;
    w_carry_nxt = r_carry;
    w_err_nxt   = r_err;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_we_a      = 1'b0;
    w_idx_a     = '0;
    w_dat_a     = '0;
    w_we_b      = 1'b0;
    w_idx_b     = '0;
    w_dat_b     = '0;
    w_ld_mul    = 1'b0;
    w_ld_div    = 1'b0;
    w_div_zero  = 1'b0;
    case (r_state)
      S_IDLE: if (bus.op_valid) w_state_nxt = S_EXEC;
      S_EXEC: begin
        w_state_nxt = S_IDLE;
        case (r_op)
          OP_PUSH, OP_PUSF: begin
            if (w_full) w_err_nxt = 1'b1;
            else begin
              w_we_a      = 1'b1;
              w_idx_a     = w_idx_p;
              w_dat_a     = (r_op == OP_PUSH) ? r_arg : WIDTH'({r_err, r_carry});
              w_depth_nxt = r_depth + SPW'(1);
            end
          end
          OP_DUP: begin
            if (!w_one_ok || w_full) w_err_nxt = 1'b1;
            else begin
              w_we_a      = 1'b1;
              w_idx_a     = w_idx_p;
              w_dat_a     = w_t;
              w_depth_nxt = r_depth + SPW'(1);
            end
          end
          OP_POP: begin
            if (!w_one_ok) w_err_nxt = 1'b1;
            else w_depth_nxt = r_depth - SPW'(1);
          end
          OP_OUT: begin
            if (!w_one_ok) w_err_nxt = 1'b1;
            else w_out_nxt = w_t;
          end
          OP_SWAP: begin
            if (!w_two_ok) w_err_nxt = 1'b1;
            else begin
              w_we_a  = 1'b1;
              w_idx_a = w_idx_t;
              w_dat_a = w_s;
              w_we_b  = 1'b1;
              w_idx_b = w_idx_s;
              w_dat_b = w_t;
            end
          end
          OP_BINA: begin
            if (!w_two_ok) w_err_nxt = 1'b1;
            else begin
              w_we_a      = 1'b1;
              w_idx_a     = w_idx_s;
              w_dat_a     = w_bina[WIDTH-1:0];
              w_carry_nxt = w_bina[WIDTH];
              w_depth_nxt = r_depth - SPW'(1);
            end
          end
          OP_MULT: begin
            if (!w_two_ok) w_err_nxt = 1'b1;
            else begin
              w_we_a      = 1'b1;
              w_idx_a     = w_idx_s;
              w_dat_a     = w_prod[WIDTH-1:0];
              w_depth_nxt = r_depth - SPW'(1);
              w_ld_mul    = 1'b1;
              w_state_nxt = S_WR2;
            end
          end
          OP_IDIV: begin
            if (!w_two_ok) w_err_nxt = 1'b1;
            else if (w_t == '0) begin
              w_err_nxt   = 1'b1;
              w_div_zero  = 1'b1;
              w_state_nxt = S_WR2;
            end else begin
              w_ld_div    = 1'b1;
              w_cnt_nxt   = CW'(WIDTH - 1);
              w_state_nxt = S_DIV;
            end
          end
          OP_CLFL: begin
            w_carry_nxt = 1'b0;
            w_err_nxt   = 1'b0;
          end
          default: ;
        endcase
      end
      S_DIV: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == '0) w_state_nxt = S_WR2;
      end
      S_WR2: begin
        w_state_nxt = S_IDLE;
        w_we_a      = 1'b1;
        if (r_op == OP_MULT) begin
          w_idx_a     = w_idx_p;
          w_dat_a     = r_hi;
          w_depth_nxt = r_depth + SPW'(1);
        end else begin
          w_idx_a = w_idx_s;
          w_dat_a = r_quo;
          w_we_b  = 1'b1;
          w_idx_b = w_idx_t;
          w_dat_b = r_rem;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_depth <= '0;
      r_carry <= 1'b0;
      r_err   <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_depth <= w_depth_nxt;
      r_carry <= w_carry_nxt;
      r_err   <= w_err_nxt;
      r_out   <= w_out_nxt;
      r_done  <= (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Stack storage and datapath registers carry no reset; control state gates their use.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.op_valid) begin
      r_op  <= bus.op;
      r_arg <= bus.in_data;
    end
    if (w_we_a) r_stk[w_idx_a] <= w_dat_a;
    if (w_we_b) r_stk[w_idx_b] <= w_dat_b;
    if (w_ld_mul) r_hi <= w_prod[2*WIDTH-1:WIDTH];
    if (w_ld_div) begin
      r_quo <= w_s;
      r_rem <= '0;
      r_dvs <= w_t;
    end else if (w_div_zero) begin
      r_quo <= '0;
      r_rem <= '0;
    end else if (r_state == S_DIV) begin
      r_quo <= w_quo_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  assign bus.op_ready = (r_state == S_IDLE);
  assign bus.done     = r_done;
  assign bus.out_data = r_out;
  assign bus.top_word = w_one_ok ? w_t : '0;
  assign bus.depth    = r_depth;
  assign bus.carry    = r_carry;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_stack_cpu_param.sv
// Scoreboarded bench for stack_cpu_param: a behavioural stack model queues the expected
// status and latency per op; each scenario task compares DUT snapshots at retirement.
module tb_stack_cpu_param;
  localparam int W   = 4;
  localparam int D   = 8;
  localparam int SPW = $clog2(D + 1);

  typedef struct packed {
    logic [W-1:0]   top;
    logic [SPW-1:0] depth;
    logic           carry;
    logic           err;
    logic [W-1:0]   out;
    logic [7:0]     lat;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stack_cpu_param_if #(.WIDTH(W), .DEPTH(D)) bus ();
  stack_cpu_param #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  snap_t exp_q[$];
  snap_t obs_q[$];
  int n_chk = 0;
  int n_err = 0;

  logic [W-1:0] m_stk [D];
  int           m_depth;
  logic         m_carry, m_err;
  logic [W-1:0] m_out;

  task automatic model_reset();
    m_depth = 0; m_carry = 1'b0; m_err = 1'b0; m_out = '0;
  endtask

  // Reference behaviour of one op; pushes the expected post-retirement snapshot.
  task automatic model(input logic [3:0] o, input logic [W-1:0] d);
    int s, t, r, lat;
    snap_t e;
    lat = 1;
    s = (m_depth >= 2) ? int'(m_stk[m_depth-2]) : 0;
    t = (m_depth >= 1) ? int'(m_stk[m_depth-1]) : 0;
    case (o)
      4'h1: if (m_depth == D) m_err = 1'b1; else begin m_stk[m_depth] = d; m_depth++; end
      4'h2: if (m_depth < 1) m_err = 1'b1; else m_depth--;
      4'h3: if (m_depth < 1) m_err = 1'b1; else m_out = W'(t);
      4'h4: if (m_depth < 2) m_err = 1'b1;
            else begin m_stk[m_depth-1] = W'(s); m_stk[m_depth-2] = W'(t); end
      4'h5: if (m_depth < 1 || m_depth == D) m_err = 1'b1;
            else begin m_stk[m_depth] = W'(t); m_depth++; end
      4'h6: if (m_depth == D) m_err = 1'b1;
            else begin m_stk[m_depth] = W'({m_err, m_carry}); m_depth++; end
      4'h8: if (m_depth < 2) m_err = 1'b1;
            else begin
              case (d[2:0])
                3'd0: begin r = s + t; m_carry = (r >= (1 << W)); end
                3'd1: begin r = s + t + int'(m_carry); m_carry = (r >= (1 << W)); end
                3'd2: begin r = s - t; m_carry = (s < t); end
                3'd3: r = s & t;
                3'd4: r = s | t;
                3'd5: r = s ^ t;
                default: r = 0;
              endcase
              m_depth--;
              m_stk[m_depth-1] = W'(r);
            end
      4'h9: if (m_depth < 2) m_err = 1'b1;
            else begin
              r = s * t;
              m_stk[m_depth-2] = W'(r);
              m_stk[m_depth-1] = W'(r >> W);
              lat = 2;
            end
      4'hA: if (m_depth < 2) m_err = 1'b1;
            else if (t == 0) begin
              m_err = 1'b1; m_stk[m_depth-2] = '0; m_stk[m_depth-1] = '0; lat = 2;
            end else begin
              m_stk[m_depth-2] = W'(s / t); m_stk[m_depth-1] = W'(s % t); lat = W + 2;
            end
      4'hB: begin m_carry = 1'b0; m_err = 1'b0; end
      default: ;
    endcase
    e.top   = (m_depth == 0) ? '0 : m_stk[m_depth-1];
    e.depth = SPW'(m_depth);
    e.carry = m_carry;
    e.err   = m_err;
    e.out   = m_out;
    e.lat   = 8'(lat);
    exp_q.push_back(e);
  endtask

  // Issue one op, measure accept-to-done latency and capture status at retirement.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] d, input bit junk);
    int n;
    snap_t ob;
    model(o, d);
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = o; bus.in_data = d;
    n = 0;
    while (!bus.op_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    bus.op = junk ? 4'h1 : 4'(($urandom)); bus.in_data = W'($urandom);
    if (!junk) bus.op_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) bus.op_valid = 1'b0;
    end while (!bus.done && n < 50);
    ob.lat   = bus.done ? 8'(n) : 8'hFF;
    ob.top   = bus.top_word;
    ob.depth = bus.depth;
    ob.carry = bus.carry;
    ob.err   = bus.err;
    ob.out   = bus.out_data;
    obs_q.push_back(ob);
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({bus.op_ready, bus.done, bus.depth, bus.out_data, bus.top_word, bus.carry, bus.err} !==
        {1'b1, 1'b0, SPW'(0), W'(0), W'(0), 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_in: got rdy=%b done=%b depth=%0d out=%h top=%h c=%b e=%b, want 1 0 0 0 0 0 0",
               bus.op_ready, bus.done, bus.depth, bus.out_data, bus.top_word, bus.carry, bus.err);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_chk++;
    if ({bus.op_ready, bus.done, bus.depth, bus.err} !== {1'b1, 1'b0, SPW'(0), 1'b0}) begin
      n_err++;
      $display("FAIL reset_out: got rdy=%b done=%b depth=%0d e=%b, want 1 0 0 0",
               bus.op_ready, bus.done, bus.depth, bus.err);
    end
  endtask

  task automatic test_add();
    snap_t e, o;
    run_op(4'h1, 4'd9, 1'b0); run_op(4'h1, 4'd8, 1'b0); run_op(4'h8, 4'd0, 1'b0);
    run_op(4'h1, 4'd2, 1'b0); run_op(4'h1, 4'd3, 1'b0); run_op(4'h8, 4'd1, 1'b0);
    run_op(4'h8, 4'd2, 1'b0); run_op(4'h3, 4'd0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL add #%0d: got top=%h d=%0d c=%b e=%b out=%h lat=%0d, want top=%h d=%0d c=%b e=%b out=%h lat=%0d",
                 k, o.top, o.depth, o.carry, o.err, o.out, o.lat, e.top, e.depth, e.carry, e.err, e.out, e.lat);
      end
    end
  endtask

  task automatic test_muldiv();
    snap_t e, o;
    run_op(4'h1, 4'd7, 1'b0); run_op(4'h1, 4'd6, 1'b0); run_op(4'h9, 4'd0, 1'b0);
    run_op(4'h2, 4'd0, 1'b0);
    run_op(4'h1, 4'd13, 1'b0); run_op(4'h1, 4'd4, 1'b0); run_op(4'hA, 4'd0, 1'b1);
    run_op(4'h2, 4'd0, 1'b0);
    run_op(4'h1, 4'd15, 1'b0); run_op(4'h1, 4'd1, 1'b0); run_op(4'hA, 4'd0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL muldiv #%0d: got top=%h d=%0d c=%b e=%b out=%h lat=%0d, want top=%h d=%0d c=%b e=%b out=%h lat=%0d",
                 k, o.top, o.depth, o.carry, o.err, o.out, o.lat, e.top, e.depth, e.carry, e.err, e.out, e.lat);
      end
    end
  endtask

  task automatic test_div0_clfl();
    snap_t e, o;
    run_op(4'h1, 4'd5, 1'b0); run_op(4'h1, 4'd0, 1'b0); run_op(4'hA, 4'd0, 1'b0);
    run_op(4'h6, 4'd0, 1'b0); run_op(4'h2, 4'd0, 1'b0); run_op(4'h4, 4'd0, 1'b0);
    run_op(4'hB, 4'd0, 1'b0); run_op(4'h6, 4'd0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL div0 #%0d: got top=%h d=%0d c=%b e=%b out=%h lat=%0d, want top=%h d=%0d c=%b e=%b out=%h lat=%0d",
                 k, o.top, o.depth, o.carry, o.err, o.out, o.lat, e.top, e.depth, e.carry, e.err, e.out, e.lat);
      end
    end
  endtask

  task automatic test_bounds();
    snap_t e, o;
    do_reset();
    for (int i = 1; i <= 9; i++) run_op(4'h1, W'(i), 1'b0);
    run_op(4'h5, 4'd0, 1'b0); run_op(4'h6, 4'd0, 1'b0); run_op(4'hB, 4'd0, 1'b0);
    for (int i = 0; i < 8; i++) run_op(4'h2, 4'd0, 1'b0);
    run_op(4'h2, 4'd0, 1'b0); run_op(4'h4, 4'd0, 1'b0); run_op(4'h3, 4'd0, 1'b0);
    run_op(4'h9, 4'd0, 1'b0); run_op(4'hA, 4'd0, 1'b0); run_op(4'h5, 4'd0, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL bounds #%0d: got top=%h d=%0d c=%b e=%b out=%h lat=%0d, want top=%h d=%0d c=%b e=%b out=%h lat=%0d",
                 k, o.top, o.depth, o.carry, o.err, o.out, o.lat, e.top, e.depth, e.carry, e.err, e.out, e.lat);
      end
    end
  endtask

  task automatic test_random();
    snap_t e, o;
    logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      op = ($urandom_range(0, 2) == 0) ? 4'h1 : 4'($urandom_range(0, 15));
      run_op(op, W'($urandom), 1'b0);
    end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random #%0d: got top=%h d=%0d c=%b e=%b out=%h lat=%0d, want top=%h d=%0d c=%b e=%b out=%h lat=%0d",
                 k, o.top, o.depth, o.carry, o.err, o.out, o.lat, e.top, e.depth, e.carry, e.err, e.out, e.lat);
      end
    end
  endtask

  task automatic test_reset_mid_div();
    snap_t e, o;
    bit seen;
    do_reset();
    run_op(4'h2, 4'd0, 1'b0);
    run_op(4'h1, 4'd13, 1'b0); run_op(4'h1, 4'd4, 1'b0);
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++;
      if (o !== e) begin
        n_err++;
        $display("FAIL middiv_setup #%0d: got top=%h d=%0d e=%b lat=%0d, want top=%h d=%0d e=%b lat=%0d",
                 k, o.top, o.depth, o.err, o.lat, e.top, e.depth, e.err, e.lat);
      end
    end
    @(negedge clk); bus.op_valid = 1'b1; bus.op = 4'hA; bus.in_data = '0;
    @(posedge clk);
    @(negedge clk); bus.op_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.depth, bus.op_ready, bus.err, bus.done} !== {SPW'(0), 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL middiv_rst: got depth=%0d rdy=%b e=%b done=%b, want 0 1 0 0",
               bus.depth, bus.op_ready, bus.err, bus.done);
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    seen = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (bus.done) seen = 1'b1; end
    n_chk++;
    if (seen !== 1'b0 || bus.depth !== SPW'(0)) begin
      n_err++;
      $display("FAIL middiv_nodone: got done_seen=%b depth=%0d, want 0 0", seen, bus.depth);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op_valid = 1'b0;
    bus.op = '0;
    bus.in_data = '0;
    model_reset();
    test_reset();
    test_add();
    test_muldiv();
    test_div0_clfl();
    test_bounds();
    test_random();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
